// File: rtl/pingpong_ram.sv
// Double-buffered complex-sample frame store: one bank fills while the other drains.
// Frames complete on a last-write and are released on a last-read.
module pingpong_ram #(
   parameter int N      = 8,
   parameter int I      = 4,
   parameter int F      = 4,
   parameter int BITREV = 0,
   localparam int A     = (N > 1) ? $clog2(N) : 1,
   localparam int W     = I + F
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_wr_en,
   input  logic [A-1:0] i_wr_addr,
   input  logic [W-1:0] i_wr_re,
   input  logic [W-1:0] i_wr_im,
   input  logic         i_wr_last,
   input  logic         i_rd_en,
   input  logic [A-1:0] i_rd_addr,
   input  logic         i_rd_last,
   output logic         o_wr_ready,
   output logic         o_rd_valid,
   output logic [W-1:0] o_rd_re,
   output logic [W-1:0] o_rd_im,
   output logic         o_rd_dv,
   output logic         o_wr_ovf
);

   logic [1:0]     full;
   logic [1:0]     full_nxt;
   logic           wr_sel;
   logic           rd_sel;
   logic           wr_acc;
   logic           rd_acc;
   logic [A-1:0]   wr_addr_eff;
   logic [2*W-1:0] mem [0:2*N-1];

   // Handshake: a write transfers when i_wr_en && o_wr_ready, a read when
   // i_rd_en && o_rd_valid; the *_last qualifiers only matter on a transfer.
   assign o_wr_ready = !full[wr_sel];
   assign o_rd_valid = full[rd_sel];
   assign wr_acc     = i_wr_en && o_wr_ready;
   assign rd_acc     = i_rd_en && o_rd_valid;

   generate
      if (BITREV != 0) begin : g_rev
         always_comb begin
            wr_addr_eff = '0;
            for (int b = 0; b < A; b++) wr_addr_eff[b] = i_wr_addr[A-1-b];
         end
      end else begin : g_lin
         assign wr_addr_eff = i_wr_addr;
      end
   endgenerate

   // Write and read banks never coincide, so set and clear cannot collide.
   always_comb begin
      full_nxt = full;
      if (wr_acc && i_wr_last) full_nxt[wr_sel] = 1'b1;
      if (rd_acc && i_rd_last) full_nxt[rd_sel] = 1'b0;
   end

   // Storage is left unreset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (rst && wr_acc) mem[{wr_sel, wr_addr_eff}] <= {i_wr_re, i_wr_im};
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         full     <= 2'b00;
         wr_sel   <= 1'b0;
         rd_sel   <= 1'b0;
         o_rd_re  <= '0;
         o_rd_im  <= '0;
         o_rd_dv  <= 1'b0;
         o_wr_ovf <= 1'b0;
      end else begin
         full     <= full_nxt;
         o_wr_ovf <= i_wr_en && !o_wr_ready;
         o_rd_dv  <= rd_acc;
         if (wr_acc && i_wr_last) wr_sel <= ~wr_sel;
         if (rd_acc && i_rd_last) rd_sel <= ~rd_sel;
         if (rd_acc) {o_rd_re, o_rd_im} <= mem[{rd_sel, i_rd_addr}];
      end
   end

endmodule
